// File: rtl/apb3_master_if.sv
// Command/response stream plus APB3 bus bundled for the apb3_master requester.
// The master modport is the requester's view; slave is the environment's view (host + APB slave).
interface apb3_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb3_master.sv
// Single-outstanding APB3 requester: valid/ready command in, SETUP/ACCESS on APB,
// valid/ready response out, with slave error and bounded-wait timeout reporting.
module apb3_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    apb3_master_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter value on the final permitted ACCESS cycle (TIMEOUT ACCESS cycles in total).
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [7:0]        wait_cnt_reg, wait_cnt_next;
    logic [ADDR_W-1:0] paddr_reg, paddr_next;
    logic              pwrite_reg, pwrite_next;
    logic [DATA_W-1:0] pwdata_reg, pwdata_next;
    logic              psel_reg, psel_next;
    logic              penable_reg, penable_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              rsp_timeout_reg, rsp_timeout_next;

    logic              access_done;
    logic              wait_expired;

    // pslverr/prdata are only meaningful on the qualified completion beat.
    assign access_done  = psel_reg && penable_reg && bus.pready;
    assign wait_expired = psel_reg && penable_reg && !bus.pready && (wait_cnt_reg == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            wait_cnt_reg    <= '0;
            paddr_reg       <= '0;
            pwrite_reg      <= 1'b0;
            pwdata_reg      <= '0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            paddr_reg       <= paddr_next;
            pwrite_reg      <= pwrite_next;
            pwdata_reg      <= pwdata_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (bus.cmd_valid) state_next = SETUP;
            SETUP:  state_next = ACCESS;
            ACCESS: if (access_done || wait_expired) state_next = RESP;
            RESP:   if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes follow the next state so they appear registered in the state's own cycle.
    always_comb begin
        wait_cnt_next    = wait_cnt_reg;
        paddr_next       = paddr_reg;
        pwrite_next      = pwrite_reg;
        pwdata_next      = pwdata_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_err_next     = rsp_err_reg;
        rsp_timeout_next = rsp_timeout_reg;
        psel_next        = (state_next == SETUP) || (state_next == ACCESS);
        penable_next     = (state_next == ACCESS);
        rsp_valid_next   = (state_next == RESP);

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_next  = bus.cmd_addr;
                    pwrite_next = bus.cmd_write;
                    if (bus.cmd_write) pwdata_next = bus.cmd_wdata;
                end
            end
            ACCESS: begin
                if (access_done) begin
                    rsp_rdata_next   = pwrite_reg ? '0 : bus.prdata;
                    rsp_err_next     = bus.pslverr;
                    rsp_timeout_next = 1'b0;
                end else if (wait_expired) begin
                    rsp_rdata_next   = '0;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) wait_cnt_next = '0;
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready   = (state_reg == IDLE);
    assign bus.paddr       = paddr_reg;
    assign bus.pwrite      = pwrite_reg;
    assign bus.pwdata      = pwdata_reg;
    assign bus.psel        = psel_reg;
    assign bus.penable     = penable_reg;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.rsp_err     = rsp_err_reg;
    assign bus.rsp_timeout = rsp_timeout_reg;

    a_penable_needs_psel: assert property (@(posedge clk) disable iff (!rst_n)
        bus.penable |-> bus.psel);
    a_access_ends_on_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.psel && bus.penable && bus.pready) |=> !bus.penable);
endmodule

// File: doc/apb3_master.md
Name: apb3_master

Overview:
- Single-outstanding APB3 requester. Converts a valid/ready command stream into APB3 SETUP/ACCESS transfers and returns a response with a valid/ready handshake.
- Sits between a debug host bridge (for example a UART or JTAG command decoder) and the CPU debug APB3 slave port.
- Supports slave wait states through pready, error return through pslverr, and a bounded-wait timeout.

Parameters:
- ADDR_W, 12, APB address width (matches the debug slave paddr).
- DATA_W, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles to wait for pready before aborting; legal range 1..255.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
- rsp_err  out  1  pslverr was sampled high, or a timeout occurred.
- rsp_timeout  out  1  the transfer was aborted by timeout.
- paddr  out  ADDR_W  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset: a clock edge with rst_n low forces IDLE. All outputs go to 0, the wait counter goes to 0 and response registers clear. This applies mid-transfer: psel and penable drop on the next edge with no completion and no response.
- All APB outputs and rsp_* outputs are registered. cmd_ready is combinational: high exactly when the state is IDLE.
- State IDLE:
  - If cmd_valid is high, latch addr/write/wdata into paddr/pwrite/pwdata and go to SETUP.
  - pwdata is loaded only for writes; otherwise it keeps its previous value.
- State SETUP: psel=1, penable=0. Always goes to ACCESS after 1 cycle.
- State ACCESS: psel=1, penable=1; paddr, pwrite and pwdata stay stable.
  - pready=1: capture prdata (reads only; writes capture 0) and capture pslverr into rsp_err. Set rsp_timeout=0, drop psel/penable and go to RESP.
  - pready=0: increment the wait counter.
  - Timeout: if the counter reaches TIMEOUT-1 with pready still 0, abort. Drop psel/penable, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, and go to RESP.
  - pready=1 on the same cycle as the timeout threshold counts as normal completion; no timeout is reported.
- State RESP: rsp_valid=1, and rsp_* are held stable. When rsp_ready is high, go to IDLE: rsp_valid=0 and the wait counter clears.
- pslverr is sampled only when psel, penable and pready are all high; it is ignored otherwise.
- Latency with pready tied high:
  - command accepted at edge T;
  - SETUP visible in cycle T+1, ACCESS in cycle T+2;
  - rsp_valid visible in cycle T+3.
  - With rsp_ready held high, cmd_ready returns in cycle T+4. Throughput is 1 transfer per 4 cycles.
- Each pready=0 cycle in ACCESS adds 1 cycle of latency.
- Only one transfer is outstanding. cmd_valid is ignored outside IDLE; the command source must hold it until accepted.
- psel is never high with penable high for more than one cycle after pready. penable is never high without psel.

Test Plan:
- Write, no wait states: cmd write addr=0x000 wdata=0x0000_0001 → SETUP with paddr=0x000, pwrite=1, pwdata=1, psel=1, penable=0. Next cycle penable=1. rsp_valid 3 cycles after acceptance with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: slave returns prdata=0xDEAD_BEEF after pready=0 for 3 cycles → ACCESS lasts 4 cycles, paddr stays stable, rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_timeout=0.
- Slave error: read addr=0x004 with pready=1, pslverr=1 → rsp_err=1, rsp_timeout=0. With pslverr pulsed while pready=0 → rsp_err=0.
- Timeout: TIMEOUT=16, pready held 0 → psel drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. A second command afterwards completes normally.
- Response backpressure: rsp_ready=0 for 5 cycles after completion → rsp_valid and rsp_rdata held stable, cmd_ready=0, no new SETUP starts. Releasing rsp_ready gives cmd_ready=1 the next cycle.
- Reset during ACCESS: drive rst_n low while penable=1 and pready=0 → after the edge psel=0, penable=0, rsp_valid=0, cmd_ready=1 once rst_n returns high, and no stale response appears.
